stage_pipe_reg: RTL and testbench

- Parametrised pipeline register for decode-to-execute and any later stage boundary in the RISC-V core.
- Carries the ALU operation, ALU result-select, two operands, destination register address and write-enable.
- Adds a valid/ready handshake, a flush for branch or exception kill, and bubble insertion.
- Whenever no valid instruction is held, the outputs carry a canonical NOP, so downstream logic never writes the register file by accident.

---
 rtl/stage_pipe_reg_pkg.sv | 18 +
 rtl/stage_skid_buf.sv | 50 +++++
 rtl/stage_pipe_reg.sv | 159 +++++++++++++++
 tb/tb_stage_pipe_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/stage_pipe_reg_pkg.sv
// Shared constants for stage_pipe_reg: reset level, canonical NOP field
// values and default field widths.
package stage_pipe_reg_pkg;

   localparam logic        RstEnable    = 1'b1;
   localparam logic [7:0]  EXE_NOP_OP   = 8'h00;
   localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;
   localparam logic [4:0]  NOPRegAddr   = 5'b00000;
   localparam logic        WriteDisable = 1'b0;

   localparam int DEF_ALUOP_W  = 8;
   localparam int DEF_ALUSEL_W = 3;
   localparam int DEF_REG_W    = 32;
   localparam int DEF_RADDR_W  = 5;
   localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/stage_skid_buf.sv
// One-entry payload holder with full flag. Used as the second slot behind
// the output register of stage_pipe_reg when STAGE_PIPE_SKID_EN is defined.
module stage_skid_buf
   import stage_pipe_reg_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic         unload,
   input  logic [W-1:0] din,
   output logic         full,
   output logic [W-1:0] dout
);

   logic         full_q, full_d;
   logic [W-1:0] data_q, data_d;

   // Next state: clear wins, a load in the same cycle as an unload refills.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (clr) begin
         full_d = 1'b0;
      end else begin
         if (unload) full_d = 1'b0;
         if (load) begin
            full_d = 1'b1;
            data_d = din;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign full = full_q;
   assign dout = data_q;

endmodule

// File: rtl/stage_pipe_reg.sv
// Valid/ready pipeline register between core stages. Carries ALU op/sel,
// two operands and the destination write port; shows a canonical NOP
// whenever it holds no valid instruction. Flush kills held and incoming
// entries. Optional macro STAGE_PIPE_SKID_EN adds a one-entry skid buffer
// and makes in_ready a register.
module stage_pipe_reg
   import stage_pipe_reg_pkg::*;
#(
   parameter int ALUOP_W  = DEF_ALUOP_W,
   parameter int ALUSEL_W = DEF_ALUSEL_W,
   parameter int REG_W    = DEF_REG_W,
   parameter int RADDR_W  = DEF_RADDR_W,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ALUOP_W-1:0]  in_aluop,
   input  logic [ALUSEL_W-1:0] in_alusel,
   input  logic [REG_W-1:0]    in_reg1,
   input  logic [REG_W-1:0]    in_reg2,
   input  logic [RADDR_W-1:0]  in_wd,
   input  logic                in_wreg,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ALUOP_W-1:0]  out_aluop,
   output logic [ALUSEL_W-1:0] out_alusel,
   output logic [REG_W-1:0]    out_reg1,
   output logic [REG_W-1:0]    out_reg2,
   output logic [RADDR_W-1:0]  out_wd,
   output logic                out_wreg,
   output logic [CNT_W-1:0]    bubble_cnt
);

   localparam int PAY_W = ALUOP_W + ALUSEL_W + 2*REG_W + RADDR_W + 1;

   logic [PAY_W-1:0] in_pay, nop_pay;
   logic [PAY_W-1:0] out_pay_q, out_pay_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic             acc, cons;

   assign in_pay  = {in_aluop, in_alusel, in_reg1, in_reg2, in_wd, in_wreg};
   assign nop_pay = {ALUOP_W'(EXE_NOP_OP), ALUSEL_W'(EXE_RES_NOP),
                     REG_W'(ZeroWord), REG_W'(ZeroWord),
                     RADDR_W'(NOPRegAddr), WriteDisable};
   assign cons    = out_valid_q & out_ready;

`ifdef STAGE_PIPE_SKID_EN
   logic             in_ready_q, in_ready_d;
   logic             skid_full, skid_load, skid_unload, skid_full_nxt;
   logic [PAY_W-1:0] skid_dout;

   assign in_ready = in_ready_q;
   assign acc      = in_valid & in_ready_q;

   // Output slot and skid control: skid drains into out on consume, an
   // accept during a stall parks in skid.
   always_comb begin
      out_valid_d = out_valid_q;
      out_pay_d   = out_pay_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      if (flush) begin
         out_valid_d = 1'b0;
         out_pay_d   = nop_pay;
      end else if (cons) begin
         if (skid_full) begin
            out_valid_d = 1'b1;
            out_pay_d   = skid_dout;
            skid_unload = 1'b1;
            skid_load   = acc;
         end else if (acc) begin
            out_valid_d = 1'b1;
            out_pay_d   = in_pay;
         end else begin
            out_valid_d = 1'b0;
            out_pay_d   = nop_pay;
         end
      end else if (!out_valid_q) begin
         if (acc) begin
            out_valid_d = 1'b1;
            out_pay_d   = in_pay;
         end
      end else begin
         skid_load = acc;
      end
   end

   // in_ready tracks next-cycle skid emptiness, so it never depends on out_ready combinationally.
   always_comb begin
      skid_full_nxt = flush ? 1'b0 : (skid_load | (skid_full & ~skid_unload));
      in_ready_d    = ~skid_full_nxt;
   end

   // Registered ready, low during reset.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) in_ready_q <= 1'b0;
      else                  in_ready_q <= in_ready_d;
   end

   stage_skid_buf #(.W(PAY_W)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .clr    (flush),
      .load   (skid_load),
      .unload (skid_unload),
      .din    (in_pay),
      .full   (skid_full),
      .dout   (skid_dout)
   );
`else
   assign in_ready = ~out_valid_q | out_ready;
   assign acc      = in_valid & in_ready;

   // Output slot: load on accept, NOP bubble on consume-only, else hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_pay_d   = out_pay_q;
      if (flush) begin
         out_valid_d = 1'b0;
         out_pay_d   = nop_pay;
      end else if (acc) begin
         out_valid_d = 1'b1;
         out_pay_d   = in_pay;
      end else if (cons) begin
         out_valid_d = 1'b0;
         out_pay_d   = nop_pay;
      end
   end
`endif

   // Bubble counter: counts edges that see an empty output, saturating.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (!out_valid_q && (bubble_cnt_q != {CNT_W{1'b1}}))
         bubble_cnt_d = bubble_cnt_q + 1'b1;
   end

   // Output and counter registers.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         out_valid_q  <= 1'b0;
         out_pay_q    <= nop_pay;
         bubble_cnt_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_pay_q    <= out_pay_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign {out_aluop, out_alusel, out_reg1, out_reg2, out_wd, out_wreg} = out_pay_q;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Directed plus random bench for stage_pipe_reg (default build). A second
// instance with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_stage_pipe_reg;

   typedef struct packed {
      logic [7:0]  op;
      logic [2:0]  sel;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  wd;
      logic        wreg;
   } pay_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, in_valid, out_ready;
   pay_t        cur;
   logic        in_ready, out_valid, out_wreg;
   logic [7:0]  out_aluop;
   logic [2:0]  out_alusel;
   logic [31:0] out_reg1, out_reg2;
   logic [4:0]  out_wd;
   logic [15:0] bubble_cnt;

   logic        s_in_ready, s_out_valid, s_out_wreg;
   logic [7:0]  s_out_aluop;
   logic [2:0]  s_out_alusel;
   logic [31:0] s_out_reg1, s_out_reg2;
   logic [4:0]  s_out_wd;
   logic [3:0]  s_bubble_cnt;

   stage_pipe_reg u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_aluop(cur.op), .in_alusel(cur.sel), .in_reg1(cur.r1), .in_reg2(cur.r2),
      .in_wd(cur.wd), .in_wreg(cur.wreg),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_aluop(out_aluop), .out_alusel(out_alusel), .out_reg1(out_reg1),
      .out_reg2(out_reg2), .out_wd(out_wd), .out_wreg(out_wreg),
      .bubble_cnt(bubble_cnt)
   );

   stage_pipe_reg #(.CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .in_aluop(cur.op), .in_alusel(cur.sel), .in_reg1(cur.r1), .in_reg2(cur.r2),
      .in_wd(cur.wd), .in_wreg(cur.wreg),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_aluop(s_out_aluop), .out_alusel(s_out_alusel), .out_reg1(s_out_reg1),
      .out_reg2(s_out_reg2), .out_wd(s_out_wd), .out_wreg(s_out_wreg),
      .bubble_cnt(s_bubble_cnt)
   );

   pay_t exp_q[$];
   int   cnt16, cnt4;
   int   n_cmp = 0, n_err = 0;
   bit   last_acc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check pre-edge outputs against the model, advance the model, take the edge.
   task automatic tick(input bit chk_en);
      pay_t e;
      bit   rdy, cons, acc;
      #2;
      rdy = (exp_q.size() == 0) || out_ready;
      e   = (exp_q.size() != 0) ? exp_q[0] : '0;
      if (chk_en) begin
         chk("in_ready",   in_ready,    rdy);
         chk("out_valid",  out_valid,   exp_q.size() != 0);
         chk("sat_valid",  s_out_valid, exp_q.size() != 0);
         chk("out_aluop",  out_aluop,   e.op);
         chk("out_alusel", out_alusel,  e.sel);
         chk("out_reg1",   out_reg1,    e.r1);
         chk("out_reg2",   out_reg2,    e.r2);
         chk("out_wd",     out_wd,      e.wd);
         chk("out_wreg",   out_wreg,    e.wreg);
      end
      acc      = in_valid && rdy;
      last_acc = acc;
      if (rst) begin
         exp_q.delete();
         cnt16 = 0;
         cnt4  = 0;
      end else begin
         if (exp_q.size() == 0) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt4 < 15) cnt4++;
         end
         if (flush) begin
            exp_q.delete();
         end else begin
            cons = (exp_q.size() != 0) && out_ready;
            if (cons) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(cur);
         end
      end
      @(posedge clk);
      #1;
      if (chk_en || rst) begin
         chk("bubble_cnt", bubble_cnt,   cnt16[15:0]);
         chk("bubble_sat", s_bubble_cnt, cnt4[3:0]);
      end
   endtask

   function automatic pay_t mk(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd);
      pay_t p;
      p.op   = r1[7:0] ^ 8'h5A;
      p.sel  = r2[2:0] | 3'b001;
      p.r1   = r1;
      p.r2   = r2;
      p.wd   = wd;
      p.wreg = 1'b1;
      return p;
   endfunction

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cur = mk(32'h1, 32'h2, 5'd1);
      #1;
      // Reset, two cycles.
      tick(0);
      tick(0);
      rst = 1'b0;
      // Idle five cycles.
      repeat (5) tick(1);
      chk("idle_bubble5", bubble_cnt, 16'd5);

      // Streaming three back-to-back.
      in_valid = 1'b1;
      cur = mk(32'h11, 32'hA1, 5'd3);  tick(1);
      cur = mk(32'h22, 32'hA2, 5'd4);  tick(1);
      cur = mk(32'h33, 32'hA3, 5'd5);  tick(1);
      in_valid = 1'b0;
      chk("stream_last", out_reg1, 32'h33);
      tick(1);
      tick(1);

      // Stall holding DEADBEEF; next payload waits upstream.
      in_valid = 1'b1;
      cur = mk(32'h44, 32'hDEADBEEF, 5'd7); tick(1);
      out_ready = 1'b0;
      cur = mk(32'h55, 32'h0BADF00D, 5'd8);
      repeat (3) tick(1);
      chk("stall_reg2", out_reg2, 32'hDEADBEEF);
      chk("stall_ready", in_ready, 1'b0);
      out_ready = 1'b1; tick(1);            // consume + accept, no bubble
      in_valid = 1'b0;  tick(1);
      tick(1);

      // Flush mid-stall with an incoming offer that must be discarded.
      in_valid = 1'b1;
      cur = mk(32'h66, 32'h77, 5'd9); tick(1);
      out_ready = 1'b0;
      cur = mk(32'h88, 32'h99, 5'd10);
      flush = 1'b1; tick(1);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_wd",    out_wd,    5'd0);
      chk("flush_wreg",  out_wreg,  1'b0);
      tick(1);
      out_ready = 1'b1;

      // Reset mid-stall.
      in_valid = 1'b1;
      cur = mk(32'hAA, 32'hBB, 5'd11); tick(1);
      out_ready = 1'b0;
      rst = 1'b1; tick(1);
      rst = 1'b0; in_valid = 1'b0;
      chk("rstmid_valid", out_valid, 1'b0);
      chk("rstmid_cnt",   bubble_cnt, 16'd0);
      out_ready = 1'b1;

      // Idle 20: 4-bit counter saturates at 15.
      repeat (20) tick(1);
      chk("sat_15", s_bubble_cnt, 4'd15);
      chk("cnt16_20", bubble_cnt, 16'd20);

      // Random traffic; upstream holds its payload until accepted.
      in_valid = 1'b0;
      last_acc = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!(in_valid && !last_acc)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            cur = mk($urandom, $urandom, 5'($urandom_range(0, 31)));
            cur.wreg = 1'($urandom);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         tick(1);
         if (flush) last_acc = 1'b1;
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) tick(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
